// File: rtl/gshare_ctrl.sv
// gshare_ctrl: training and sequencing controller for a 4-bit-history gshare predictor.
// Owns the 2-bit counter table and the in-flight queue, and flushes predictor history after reset.
module gshare_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_req,
  input  logic [3:0]       pred_adrs,
  output logic             pred_rdy,
  output logic             pred_vld,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             prdbit,
  output logic [3:0]       ctl_adrs,
  output logic             ctl_brnch,
  output logic             ctl_shft,
  output logic             ctl_in,
  output logic [15:0]      ctl_sram,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNTQ_W = PTR_W + 1;
  localparam logic [CNTQ_W-1:0] DEPTH_C = CNTQ_W'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         init_cnt_q, init_cnt_d;
  logic [3:0]         ghist_q, ghist_d;
  logic [1:0]         ctr_q [16];
  logic [1:0]         ctr_d [16];
  logic [4:0]         fifo_q [DEPTH];
  logic [4:0]         fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTQ_W-1:0]  count_q, count_d;
  logic               pred_vld_q, pred_vld_d;
  logic [CNT_W-1:0]   mispred_q, mispred_d;
  logic               err_q, err_d;

  logic               push_s;
  logic               pop_s;
  logic [3:0]         req_idx_s;
  logic [3:0]         res_idx_s;
  logic               res_bit_s;

  assign push_s     = pred_req & pred_rdy;
  assign pop_s      = res_valid & (state_q == ST_RUN) & (count_q != {CNTQ_W{1'b0}});
  assign req_idx_s  = pred_adrs ^ ghist_q;
  assign res_idx_s  = fifo_q[rd_ptr_q][4:1];
  assign res_bit_s  = fifo_q[rd_ptr_q][0];

  assign ctl_adrs    = pred_adrs;
  assign ctl_brnch   = push_s;
  assign ctl_in      = pop_s & res_taken;
  assign pred_vld    = pred_vld_q;
  assign pred_taken  = pred_vld_q & prdbit;
  assign mispred_cnt = mispred_q;
  assign err         = err_q;

  // Expose the MSB of every counter as the predictor's sram vector
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ctl_sram[i] = ctr_q[i][1];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // FSM next state and control outputs; INIT shifts four zeros into the history
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pred_rdy   = 1'b0;
    ctl_shft   = 1'b0;
    case (state_q)
      ST_INIT: begin
        ctl_shft   = 1'b1;
        init_cnt_d = init_cnt_q + 2'd1;
        if (init_cnt_q == 2'd3) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        pred_rdy = (count_q < DEPTH_C);
        ctl_shft = pop_s;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Datapath registers: history, counter table, queue and status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghist_q <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        ctr_q[i] <= 2'b01;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 5'd0;
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNTQ_W{1'b0}};
      pred_vld_q <= 1'b0;
      mispred_q  <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      ghist_q    <= ghist_d;
      ctr_q      <= ctr_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pred_vld_q <= pred_vld_d;
      mispred_q  <= mispred_d;
      err_q      <= err_d;
    end
  end

  // Push/pop, counter training and mispredict accounting; the stored bit is the pre-train MSB
  always_comb begin
    ghist_d    = ghist_q;
    ctr_d      = ctr_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pred_vld_d = push_s;
    mispred_d  = mispred_q;
    err_d      = err_q;

    if (push_s) begin
      fifo_d[wr_ptr_q] = {req_idx_s, ctr_q[req_idx_s][1]};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (res_taken && (ctr_q[res_idx_s] != 2'b11)) begin
        ctr_d[res_idx_s] = ctr_q[res_idx_s] + 2'b01;
      end else if (!res_taken && (ctr_q[res_idx_s] != 2'b00)) begin
        ctr_d[res_idx_s] = ctr_q[res_idx_s] - 2'b01;
      end else begin
        ctr_d[res_idx_s] = ctr_q[res_idx_s];
      end
      if ((res_taken != res_bit_s) && (mispred_q != {CNT_W{1'b1}})) begin
        mispred_d = mispred_q + CNT_W'(1);
      end else begin
        mispred_d = mispred_q;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTQ_W'(1);
      2'b01:   count_d = count_q - CNTQ_W'(1);
      default: count_d = count_q;
    endcase

    if (ctl_shft) begin
      ghist_d = {ghist_q[2:0], ctl_in};
    end else begin
      ghist_d = ghist_q;
    end

    if (res_valid && !pop_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

endmodule

// File: tb/tb_gshare_ctrl.sv
// Directed self-checking bench for gshare_ctrl: reset flush, training, saturation,
// full queue, simultaneous push/pop, empty resolve and mid-run reset.
module tb_gshare_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pred_req;
  logic [3:0]  pred_adrs;
  logic        pred_rdy;
  logic        pred_vld;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        prdbit;
  logic [3:0]  ctl_adrs;
  logic        ctl_brnch;
  logic        ctl_shft;
  logic        ctl_in;
  logic [15:0] ctl_sram;
  logic [7:0]  mispred_cnt;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Saturation walk on counter 3; addresses pre-computed against the evolving history
  logic [3:0]  sat_adrs  [9] = '{4'h0, 4'h4, 4'hC, 4'hC, 4'hC, 4'hD, 4'hF, 4'hB, 4'h3};
  logic        sat_taken [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] sat_sram  [9] = '{16'h0028, 16'h0028, 16'h0028, 16'h0028, 16'h0028,
                                 16'h0020, 16'h0020, 16'h0020, 16'h0020};
  logic [7:0]  sat_mis   [9] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd4};
  logic [15:0] prev_sram;

  gshare_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pred_req    (pred_req),
    .pred_adrs   (pred_adrs),
    .pred_rdy    (pred_rdy),
    .pred_vld    (pred_vld),
    .pred_taken  (pred_taken),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .prdbit      (prdbit),
    .ctl_adrs    (ctl_adrs),
    .ctl_brnch   (ctl_brnch),
    .ctl_shft    (ctl_shft),
    .ctl_in      (ctl_in),
    .ctl_sram    (ctl_sram),
    .mispred_cnt (mispred_cnt),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flush();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("flush_shft", 32'(ctl_shft), 32'd1);
      chk("flush_in", 32'(ctl_in), 32'd0);
      chk("flush_rdy", 32'(pred_rdy), 32'd0);
      tick();
    end
    #1;
    chk("run_rdy", 32'(pred_rdy), 32'd1);
    chk("run_shft", 32'(ctl_shft), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pred_req  = 1'b1;
    pred_adrs = 4'h0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    prdbit    = 1'b1;

    // Reset values
    tick();
    chk("rst_rdy", 32'(pred_rdy), 32'd0);
    chk("rst_vld", 32'(pred_vld), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_brnch", 32'(ctl_brnch), 32'd0);
    chk("rst_shft", 32'(ctl_shft), 32'd1);
    chk("rst_in", 32'(ctl_in), 32'd0);
    chk("rst_sram", 32'(ctl_sram), 32'h0000);
    chk("rst_mis", 32'(mispred_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    pred_req = 1'b0;
    prdbit   = 1'b0;
    check_flush();

    // Basic train: idx 5, taken, stored bit 0 -> mispredict
    pred_req  = 1'b1;
    pred_adrs = 4'h5;
    #1;
    chk("basic_brnch", 32'(ctl_brnch), 32'd1);
    chk("basic_adrs", 32'(ctl_adrs), 32'h5);
    tick();
    pred_req = 1'b0;
    chk("basic_vld", 32'(pred_vld), 32'd1);
    chk("basic_taken0", 32'(pred_taken), 32'd0);
    prdbit = 1'b1;
    #1;
    chk("basic_taken1", 32'(pred_taken), 32'd1);
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    chk("basic_shft", 32'(ctl_shft), 32'd1);
    chk("basic_in", 32'(ctl_in), 32'd1);
    tick();
    res_valid = 1'b0;
    #1;
    chk("basic_sram", 32'(ctl_sram), 32'h0020);
    chk("basic_mis", 32'(mispred_cnt), 32'd1);
    chk("basic_vld_off", 32'(pred_vld), 32'd0);
    chk("basic_taken_off", 32'(pred_taken), 32'd0);

    // History now 0001: adrs 4 maps to idx 5 (bit 1), taken -> no mispredict
    pred_req  = 1'b1;
    pred_adrs = 4'h4;
    tick();
    pred_req  = 1'b0;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    #1;
    chk("ghist_mis", 32'(mispred_cnt), 32'd1);
    chk("ghist_sram", 32'(ctl_sram), 32'h0020);

    // Saturation on counter 3
    prev_sram = 16'h0020;
    for (int i = 0; i < 9; i++) begin
      pred_req  = 1'b1;
      pred_adrs = sat_adrs[i];
      #1;
      chk("sat_brnch", 32'(ctl_brnch), 32'd1);
      tick();
      pred_req  = 1'b0;
      res_valid = 1'b1;
      res_taken = sat_taken[i];
      #1;
      chk("sat_sram_pre", 32'(ctl_sram), 32'(prev_sram));
      tick();
      res_valid = 1'b0;
      #1;
      chk("sat_sram", 32'(ctl_sram), 32'(sat_sram[i]));
      chk("sat_mis", 32'(mispred_cnt), 32'(sat_mis[i]));
      prev_sram = sat_sram[i];
    end

    // Full queue: four accepts of idx 0, then a resolve while full
    pred_req  = 1'b1;
    pred_adrs = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_rdy", 32'(pred_rdy), 32'd1);
      tick();
    end
    chk("full_rdy_low", 32'(pred_rdy), 32'd0);
    chk("full_brnch_low", 32'(ctl_brnch), 32'd0);
    res_valid = 1'b1;
    res_taken = 1'b0;
    #1;
    chk("full_pop_brnch", 32'(ctl_brnch), 32'd0);
    tick();
    res_valid = 1'b0;
    chk("full_rdy_back", 32'(pred_rdy), 32'd1);
    chk("full_vld_off", 32'(pred_vld), 32'd0);
    pred_req = 1'b0;
    tick();

    // Simultaneous push (idx 6 from pre-shift history 0000) and taken resolve of idx 0
    pred_req  = 1'b1;
    pred_adrs = 4'h6;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    pred_adrs = 4'h0;
    chk("simul_rdy", 32'(pred_rdy), 32'd1);
    chk("simul_mis", 32'(mispred_cnt), 32'd5);
    tick();
    pred_req = 1'b0;
    chk("simul_full", 32'(pred_rdy), 32'd0);

    // Drain four entries (idx 0, 0, 6, 1), all taken with stored bit 0
    res_valid = 1'b1;
    res_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    res_valid = 1'b0;
    #1;
    chk("drain_mis", 32'(mispred_cnt), 32'd9);
    chk("drain_sram", 32'(ctl_sram), 32'h0063);
    chk("drain_err", 32'(err), 32'd0);

    // Empty resolve: no shift, error flag set and sticky
    res_valid = 1'b1;
    res_taken = 1'b0;
    #1;
    chk("empty_shft", 32'(ctl_shft), 32'd0);
    chk("empty_in", 32'(ctl_in), 32'd0);
    tick();
    res_valid = 1'b0;
    chk("empty_err", 32'(err), 32'd1);
    chk("empty_sram", 32'(ctl_sram), 32'h0063);
    tick();
    chk("empty_err_sticky", 32'(err), 32'd1);

    // History must still be 1111: adrs A maps to idx 5 (bit 1), taken -> no mispredict
    pred_req  = 1'b1;
    pred_adrs = 4'hA;
    tick();
    pred_req  = 1'b0;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    #1;
    chk("empty_noshift_mis", 32'(mispred_cnt), 32'd9);

    // Mid-run reset with two entries queued and an accept in the reset cycle
    pred_req  = 1'b1;
    pred_adrs = 4'h0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_brnch", 32'(ctl_brnch), 32'd1);
    tick();
    pred_req = 1'b0;
    chk("mid_vld", 32'(pred_vld), 32'd0);
    chk("mid_rdy", 32'(pred_rdy), 32'd0);
    chk("mid_shft", 32'(ctl_shft), 32'd1);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_mis", 32'(mispred_cnt), 32'd0);
    chk("mid_sram", 32'(ctl_sram), 32'h0000);
    tick();
    rst_n = 1'b1;
    check_flush();
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    chk("mid_empty_shft", 32'(ctl_shft), 32'd0);
    tick();
    res_valid = 1'b0;
    chk("mid_empty_err", 32'(err), 32'd1);
    chk("mid_empty_mis", 32'(mispred_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_ctrl.md
# gshare_ctrl

Training and sequencing controller for the 4-bit-history gshare branch predictor. It owns the 16-entry table of 2-bit saturating counters and drives the predictor's `sram` vector, `brnch`, `shft` and `in` pins. It tracks up to 4 in-flight predictions in order and, on each branch resolution, trains the counter, shifts the global history and counts mispredictions. It also flushes the predictor's history register, which has no reset, after every reset.

## Interface
- `DEPTH`, 4: in-flight prediction queue entries (power of 2).
- `CNT_W`, 8: width of the mispredict counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pred_req`  in  1  a fetch requests a prediction.
- `pred_adrs`  in  4  branch address bits for the request.
- `pred_rdy`  out  1  the request is accepted this cycle when `pred_req & pred_rdy`.
- `pred_vld`  out  1  pulses one cycle after acceptance.
- `pred_taken`  out  1  equals `prdbit` while `pred_vld` is high, 0 otherwise.
- `res_valid`  in  1  resolution of the oldest in-flight branch.
- `res_taken`  in  1  actual outcome of that branch.
- `prdbit`  in  1  from the predictor.
- `ctl_adrs`  out  4  to predictor `adrs`; equals `pred_adrs`.
- `ctl_brnch`  out  1  to predictor `brnch`.
- `ctl_shft`  out  1  to predictor `shft`.
- `ctl_in`  out  1  to predictor `in`.
- `ctl_sram`  out  16  to predictor `sram`; bit i is the MSB of counter i (registered).
- `mispred_cnt`  out  CNT_W  saturating count of mispredictions.
- `err`  out  1  sticky flag: a resolution arrived with the queue empty.

## Operation
- State machine has two states:
  - INIT (reset state): `ctl_shft=1`, `ctl_in=0`, `pred_rdy=0`.
  - RUN.
  - Transition: 2-bit `init_cnt` increments each edge in INIT; INIT moves to RUN on the edge where `init_cnt==3`.
  - Result: four zeros are shifted into the predictor's history after reset.
- Shadow history `ghist[3:0]` mirrors the predictor's shift register. On each shift, `ghist <= {ghist[2:0], ctl_in}`.
- Table index for a request: `idx = pred_adrs ^ ghist`, using the pre-shift `ghist` of the accept cycle.
- `pred_rdy = (state==RUN) & (count<DEPTH)`. There is no bypass: a pop in the same cycle does not free a full queue.
- `ctl_brnch = pred_req & pred_rdy`, combinational.
- On accept, push `{idx, ctl_sram[idx]}` into the queue. The stored bit is the value the predictor registers into `prdbit` at that edge.
- On `res_valid` with queue non-empty, in RUN:
  - Pop the oldest entry.
  - Counter at its `idx`: increment if `res_taken`, else decrement, saturating at 0 and 3.
  - `ctl_shft=1`, `ctl_in=res_taken`; `ghist` shifts.
  - If `res_taken != stored bit`, `mispred_cnt` increments, saturating at all-ones.
- On `res_valid` with queue empty (or in INIT): no pop, no shift, no train; `err` is set.
- Push and pop in the same cycle are both performed; `count` is unchanged.
- `ctl_in` is 0 whenever `ctl_shft` is 0.
- Reset mid-operation, synchronous: the queue is discarded, every register returns to its reset value, and the FSM re-enters INIT.
  - Any `pred_vld` due in the next cycle is suppressed.
  - Resolutions for branches accepted before reset are ignored.

## Timing
- Reset values:
  - `pred_rdy=0`, `pred_vld=0`, `pred_taken=0`, `ctl_brnch=0`.
  - `ctl_shft=1`, `ctl_in=0`.
  - All counters 2'b01, so `ctl_sram=16'h0000`.
  - `mispred_cnt=0`, `err=0`, `ghist=0`, `count=0`.
- After `rst_n` is sampled high: `ctl_shft` stays high for 4 more cycles. `pred_rdy` is first high in the 5th cycle after release.
- Prediction latency: 1 cycle, accept edge to `pred_vld`. One prediction per cycle is sustainable.
- Counter update: the counter register and `ctl_sram` change at the resolve edge and are visible the next cycle.
- A request in the same cycle as a train of the same `idx` sees, and stores, the old bit.

## Test plan
- **Reset and flush:** hold `rst_n=0` for 3 cycles, then release.
  - `ctl_shft=1`, `ctl_in=0` for 4 cycles after release.
  - `pred_rdy` rises in cycle 5.
  - `ctl_sram=16'h0000`.
- **Basic train:** `pred_adrs=4'h5`, `ghist=0` → queue `idx=5`.
  - `res_taken=1` → counter 5 = 2'b10, `ctl_sram[5]=1`.
  - `ghist=4'b0001`, `mispred_cnt=1`.
- **Saturation:**
  - 4 consecutive taken resolutions on `idx 3` → counter stays at 3.
  - Then 5 not-taken → counter stays at 0.
  - `ctl_sram[3]` goes 0→1→0 at the correct edges.
- **Full queue:**
  - Accept 4 predictions → `pred_rdy=0` with `pred_req` held.
  - `res_valid` in that cycle → no push that cycle; `pred_rdy=1` next cycle.
- **Simultaneous events:**
  - Push and resolve in one cycle → `count` unchanged.
  - The new entry's `idx` uses the pre-shift `ghist`.
- **Empty resolve and mid-run reset:**
  - `res_valid` with the queue empty → `err=1`, no shift.
  - Assert `rst_n=0` with 2 entries queued → `count=0`, `err=0`, `mispred_cnt=0`, FSM in INIT.
